// File: rtl/calc_pkg.sv
// calc_pkg: shared types and key codes for the keypad calculator control path.
package calc_pkg;

  typedef enum logic [2:0] {
    ENTER_A     = 3'b000,
    ENTER_B     = 3'b001,
    ENTER_OP    = 3'b010,
    WAIT_ALU    = 3'b011,
    SHOW_RESULT = 3'b100
  } calcstate_t;

  typedef enum logic [1:0] {
    OP_ADD = 2'd0,
    OP_SUB = 2'd1,
    OP_MUL = 2'd2,
    OP_AND = 2'd3
  } alu_op_t;

  localparam logic [4:0] KEY_ADD = 5'h10;
  localparam logic [4:0] KEY_SUB = 5'h11;
  localparam logic [4:0] KEY_MUL = 5'h12;
  localparam logic [4:0] KEY_EXE = 5'h13;
  localparam logic [4:0] KEY_AND = 5'h14;
  localparam logic [4:0] KEY_CLR = 5'h15;

  typedef struct packed {
    logic    valid;
    alu_op_t op;
  } op_decode_t;

  // Map an operator key code onto an ALU operation; EXE and anything else is invalid.
  function automatic op_decode_t decode_op(input logic [4:0] code);
    op_decode_t d;
    d.valid = 1'b1;
    d.op    = OP_ADD;
    case (code)
      KEY_ADD: d.op = OP_ADD;
      KEY_SUB: d.op = OP_SUB;
      KEY_MUL: d.op = OP_MUL;
      KEY_AND: d.op = OP_AND;
      default: d.valid = 1'b0;
    endcase
    return d;
  endfunction

endpackage

// File: rtl/calc_sequencer_if.sv
// calc_sequencer_if: entry-path, keypad and ALU signals of the calculator sequencer.
// master = sequencer side, slave = environment (entry block / ALU / display) side.
interface calc_sequencer_if;
  import calc_pkg::*;

  logic          store_i;
  logic [15:0]   operand_i;
  logic          key_valid_i;
  logic [4:0]    key_code_i;
  calcstate_t    calcstate_o;
  logic [15:0]   alu_a_o;
  logic [15:0]   alu_b_o;
  alu_op_t       alu_op_o;
  logic          alu_start_o;
  logic          alu_done_i;
  logic [15:0]   alu_result_i;
  logic [15:0]   result_o;
  logic          result_valid_o;
  logic          err_o;

  modport master (
    input  store_i, operand_i, key_valid_i, key_code_i, alu_done_i, alu_result_i,
    output calcstate_o, alu_a_o, alu_b_o, alu_op_o, alu_start_o,
           result_o, result_valid_o, err_o
  );

  modport slave (
    output store_i, operand_i, key_valid_i, key_code_i, alu_done_i, alu_result_i,
    input  calcstate_o, alu_a_o, alu_b_o, alu_op_o, alu_start_o,
           result_o, result_valid_o, err_o
  );

endinterface

// File: rtl/calc_timeout_ctr.sv
// calc_timeout_ctr: ALU wait counter. clear zeroes, load presets LOAD_VALUE,
// enable counts up and holds once ALU_TIMEOUT is reached (expired).
module calc_timeout_ctr #(
  parameter int unsigned ALU_TIMEOUT = 64,
  parameter int unsigned LOAD_VALUE  = 1
) (
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic load,
  input  logic enable,
  output logic expired
);
  localparam int unsigned CNT_W = $clog2(ALU_TIMEOUT + 1);

  logic [CNT_W-1:0] count;

  assign expired = (count == CNT_W'(ALU_TIMEOUT));

  // Wait-cycle counter, saturating at the timeout value.
  always_ff @(posedge clk) begin
    if (reset || clear) begin
      count <= '0;
    end else if (load) begin
      count <= CNT_W'(LOAD_VALUE);
    end else if (enable && !expired) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/calc_sequencer.sv
// calc_sequencer: top-level control FSM of the keypad calculator.
// Optional feature: define CALC_CHAIN_EN so a store in SHOW_RESULT carries the
// result into operand A and continues at ENTER_OP (chained operations).
module calc_sequencer
  import calc_pkg::*;
#(
  parameter int unsigned ALU_TIMEOUT = 64
) (
  input logic              clk,
  input logic              reset,
  calc_sequencer_if.master bus
);

  calcstate_t  state;
  alu_op_t     op;
  logic [15:0] opa;
  logic [15:0] opb;
  logic [15:0] result;
  logic        result_valid;
  logic        err;
  logic        alu_start;

  logic        clear_key;
  op_decode_t  op_dec;
  logic        ctr_clear;
  logic        ctr_load;
  logic        ctr_enable;
  logic        ctr_expired;

  // Key/operator decode and timeout counter control.
  always_comb begin
    clear_key  = bus.key_valid_i && (bus.key_code_i == KEY_CLR);
    op_dec     = decode_op(bus.operand_i[4:0]);
    // Counter sits at 0 outside WAIT_ALU, is preset to 1 at the end of the
    // start cycle and then counts once per cycle until done or expiry.
    ctr_clear  = clear_key || (state != WAIT_ALU);
    ctr_load   = (state == WAIT_ALU) && alu_start;
    ctr_enable = (state == WAIT_ALU) && !alu_start;
  end

  calc_timeout_ctr #(
    .ALU_TIMEOUT (ALU_TIMEOUT),
    .LOAD_VALUE  (1)
  ) u_timeout (
    .clk     (clk),
    .reset   (reset),
    .clear   (ctr_clear),
    .load    (ctr_load),
    .enable  (ctr_enable),
    .expired (ctr_expired)
  );

  // Sequencer FSM with registered outputs; priority reset > CLEAR > done > timeout > store.
  always_ff @(posedge clk) begin
    if (reset || clear_key) begin
      state        <= ENTER_A;
      opa          <= '0;
      opb          <= '0;
      op           <= OP_ADD;
      result       <= '0;
      result_valid <= 1'b0;
      err          <= 1'b0;
      alu_start    <= 1'b0;
    end else begin
      alu_start <= 1'b0;
      case (state)
        ENTER_A: begin
          if (bus.store_i) begin
            opa   <= bus.operand_i;
            state <= ENTER_OP;
          end
        end
        ENTER_OP: begin
          if (bus.store_i) begin
            if (op_dec.valid) begin
              op    <= op_dec.op;
              state <= ENTER_B;
            end else begin
              err <= 1'b1;
            end
          end
        end
        ENTER_B: begin
          if (bus.store_i) begin
            opb       <= bus.operand_i;
            alu_start <= 1'b1;
            state     <= WAIT_ALU;
          end
        end
        WAIT_ALU: begin
          // Done during the start cycle is not honoured.
          if (!alu_start) begin
            if (bus.alu_done_i) begin
              result       <= bus.alu_result_i;
              result_valid <= 1'b1;
              state        <= SHOW_RESULT;
            end else if (ctr_expired) begin
              err   <= 1'b1;
              state <= ENTER_A;
            end
          end
        end
        SHOW_RESULT: begin
          if (bus.store_i) begin
            opb          <= '0;
            op           <= OP_ADD;
            result_valid <= 1'b0;
`ifdef CALC_CHAIN_EN
            opa          <= result;
            state        <= ENTER_OP;
`else
            opa          <= '0;
            state        <= ENTER_A;
`endif
          end
        end
        default: state <= ENTER_A;
      endcase
    end
  end

  assign bus.calcstate_o    = state;
  assign bus.alu_a_o        = opa;
  assign bus.alu_b_o        = opb;
  assign bus.alu_op_o       = op;
  assign bus.alu_start_o    = alu_start;
  assign bus.result_o       = result;
  assign bus.result_valid_o = result_valid;
  assign bus.err_o          = err;

endmodule

// File: tb/tb_calc_sequencer.sv
// tb_calc_sequencer: directed bench for calc_sequencer with a cycle-level reference
// model (timestamps instead of counters) and literal spot checks.
module tb_calc_sequencer;
  import calc_pkg::*;

  localparam int unsigned T = 8;

  logic clk = 1'b0;
  logic reset;

  calc_sequencer_if bus();

  calc_sequencer #(.ALU_TIMEOUT(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_errors = 0;
  int n_starts = 0;

  // Reference model: state as the published code, plus timestamps.
  int          m_state = 0;
  logic [15:0] m_a = '0;
  logic [15:0] m_b = '0;
  logic [15:0] m_res = '0;
  int          m_op = 0;
  bit          m_valid = 1'b0;
  bit          m_err = 1'b0;
  int          cyc = 0;
  int          start_cyc = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_step();
    int ended;
    ended = cyc;
    cyc++;
    if (reset) begin
      m_state = 0; m_a = '0; m_b = '0; m_res = '0; m_op = 0; m_valid = 0; m_err = 0;
    end else if (bus.key_valid_i && bus.key_code_i == 5'h15) begin
      m_state = 0; m_a = '0; m_b = '0; m_res = '0; m_op = 0; m_valid = 0; m_err = 0;
    end else begin
      case (m_state)
        0: if (bus.store_i) begin m_a = bus.operand_i; m_state = 2; end
        2: if (bus.store_i) begin
             case (bus.operand_i[4:0])
               5'h10: begin m_op = 0; m_state = 1; end
               5'h11: begin m_op = 1; m_state = 1; end
               5'h12: begin m_op = 2; m_state = 1; end
               5'h14: begin m_op = 3; m_state = 1; end
               default: m_err = 1;
             endcase
           end
        1: if (bus.store_i) begin m_b = bus.operand_i; m_state = 3; start_cyc = cyc; end
        3: begin
             if (ended > start_cyc && bus.alu_done_i) begin
               m_res = bus.alu_result_i; m_valid = 1; m_state = 4;
             end else if (ended - start_cyc == int'(T)) begin
               m_err = 1; m_state = 0;
             end
           end
        4: if (bus.store_i) begin
`ifdef CALC_CHAIN_EN
             m_a = m_res; m_state = 2;
`else
             m_a = '0; m_state = 0;
`endif
             m_b = '0; m_op = 0; m_valid = 0;
           end
        default: m_state = 0;
      endcase
    end
  endtask

  initial forever begin
    @(posedge clk);
    model_step();
  end

  // Per-cycle comparison of every output against the model.
  initial begin
    @(posedge clk);
    forever begin
      @(negedge clk);
      if (bus.alu_start_o) n_starts++;
      check("calcstate", bus.calcstate_o, m_state);
      check("alu_a", bus.alu_a_o, m_a);
      check("alu_b", bus.alu_b_o, m_b);
      check("alu_op", bus.alu_op_o, m_op);
      check("alu_start", bus.alu_start_o, (m_state == 3 && cyc == start_cyc) ? 1 : 0);
      check("result", bus.result_o, m_res);
      check("result_valid", bus.result_valid_o, m_valid);
      check("err", bus.err_o, m_err);
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic store(input logic [15:0] v);
    bus.store_i = 1'b1;
    bus.operand_i = v;
    tick();
    bus.store_i = 1'b0;
    bus.operand_i = '0;
  endtask

  task automatic clear_key();
    bus.key_valid_i = 1'b1;
    bus.key_code_i = 5'h15;
    tick();
    bus.key_valid_i = 1'b0;
    bus.key_code_i = '0;
  endtask

  task automatic done(input logic [15:0] r);
    bus.alu_done_i = 1'b1;
    bus.alu_result_i = r;
    tick();
    bus.alu_done_i = 1'b0;
    bus.alu_result_i = '0;
  endtask

  initial begin
    reset = 1'b1;
    bus.store_i = 1'b0;
    bus.operand_i = '0;
    bus.key_valid_i = 1'b0;
    bus.key_code_i = '0;
    bus.alu_done_i = 1'b0;
    bus.alu_result_i = '0;
    repeat (2) tick();
    reset = 1'b0;
    check("rst_state", bus.calcstate_o, 3'b000);
    check("rst_start", bus.alu_start_o, 1'b0);
    check("rst_valid", bus.result_valid_o, 1'b0);
    check("rst_err", bus.err_o, 1'b0);

    // Basic ADD: done three cycles after start.
    n_starts = 0;
    store(16'h0012); store(16'h0010); store(16'h0034);
    check("t1_start", bus.alu_start_o, 1'b1);
    repeat (3) tick();
    done(16'h0046);
    check("t1_state", bus.calcstate_o, 3'b100);
    check("t1_result", bus.result_o, 16'h0046);
    check("t1_valid", bus.result_valid_o, 1'b1);
    check("t1_nstarts", n_starts, 1);
    check("model_res", m_res, 16'h0046);
    store(16'h0000);
`ifdef CALC_CHAIN_EN
    check("t1_chain_state", bus.calcstate_o, 3'b010);
    check("t1_chain_a", bus.alu_a_o, 16'h0046);
`else
    check("t1_next_state", bus.calcstate_o, 3'b000);
    check("t1_next_a", bus.alu_a_o, 16'h0000);
`endif
    check("t1_next_valid", bus.result_valid_o, 1'b0);
    clear_key();

    // Invalid operators, sticky error, CLEAR.
    store(16'h0012); store(16'h0000);
    check("t2_err", bus.err_o, 1'b1);
    check("t2_state", bus.calcstate_o, 3'b010);
    store(16'h0013);
    check("t2_exe_state", bus.calcstate_o, 3'b010);
    store(16'h0011);
    check("t2_sub_op", bus.alu_op_o, 2'd1);
    check("t2_sticky", bus.err_o, 1'b1);
    clear_key();
    check("t2_clr_err", bus.err_o, 1'b0);
    check("t2_clr_state", bus.calcstate_o, 3'b000);

    // ALU never answers: timeout 9 cycles after start.
    store(16'h0005); store(16'h0012); store(16'h0007);
    check("t3_mul_op", bus.alu_op_o, 2'd2);
    repeat (T) tick();
    check("t3_still_wait", bus.calcstate_o, 3'b011);
    check("t3_no_err_yet", bus.err_o, 1'b0);
    tick();
    check("t3_err", bus.err_o, 1'b1);
    check("t3_state", bus.calcstate_o, 3'b000);
    clear_key();

    // CLEAR during WAIT_ALU, late done ignored.
    store(16'h0001); store(16'h0014); store(16'h0002);
    tick();
    clear_key();
    check("t4_state", bus.calcstate_o, 3'b000);
    tick();
    done(16'hFFFF);
    check("t4_result", bus.result_o, 16'h0000);
    check("t4_valid", bus.result_valid_o, 1'b0);
    check("t4_state2", bus.calcstate_o, 3'b000);

    // Done on the timeout cycle wins.
    store(16'h0003); store(16'h0011); store(16'h0001);
    repeat (T) tick();
    done(16'h0002);
    check("t5_state", bus.calcstate_o, 3'b100);
    check("t5_result", bus.result_o, 16'h0002);
    check("t5_err", bus.err_o, 1'b0);
    check("model_err", m_err, 1'b0);
    store(16'h0000);
    clear_key();

    // Done in start cycle ignored; store in WAIT_ALU ignored.
    store(16'h0009); store(16'h0012); store(16'h0004);
    bus.alu_done_i = 1'b1; bus.alu_result_i = 16'h1234;
    bus.store_i = 1'b1; bus.operand_i = 16'hFFFF;
    tick();
    bus.alu_done_i = 1'b0; bus.alu_result_i = '0;
    bus.store_i = 1'b0; bus.operand_i = '0;
    check("t6_state", bus.calcstate_o, 3'b011);
    check("t6_valid", bus.result_valid_o, 1'b0);
    check("t6_b", bus.alu_b_o, 16'h0004);
    tick();
    done(16'h0024);
    check("t6_result", bus.result_o, 16'h0024);
    check("t6_state2", bus.calcstate_o, 3'b100);
    clear_key();

    repeat (2) tick();
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/calc_sequencer.md
# calc_sequencer

Top-level control FSM of the keypad calculator. Consumes operand/operator store events from the number-entry block, publishes the `calcstate` code that block uses to decide what to accept, and issues a start/done handshake to the ALU. Captures the result, flags errors and handles global clear; sits between the keypad/entry path and the ALU/display.

## Interface
- `ALU_TIMEOUT`, default 64: max cycles to wait for `alu_done_i` after `alu_start_o`.
- `clk` in 1: clock.
- `reset` in 1: reset, synchronous, active-high.
- `store_i` in 1: one-cycle store strobe from the entry block; `operand_i` is valid in the same cycle.
- `operand_i` in 16: operand value, or operator code in bits [4:0] during ENTER_OP.
- `key_valid_i` in 1: one-cycle keypad strobe.
- `key_code_i` in 5: key code; 5'h15 = CLEAR.
- `calcstate_o` out 3: current state code.
- `alu_a_o`, `alu_b_o` out 16: ALU operands.
- `alu_op_o` out 2: ALU operation.
- `alu_start_o` out 1: one-cycle start pulse.
- `alu_done_i` in 1: ALU completion strobe.
- `alu_result_i` in 16: valid when `alu_done_i` = 1.
- `result_o` out 16: captured result.
- `result_valid_o` out 1: `result_o` holds a fresh result.
- `err_o` out 1: sticky error.

## Operation
- State codes: ENTER_A=000, ENTER_B=001, ENTER_OP=010, WAIT_ALU=011, SHOW_RESULT=100. The entry block accepts digits in every state except 010 and 011, and operators only in 010.
- Reset: state ENTER_A. All outputs and internal registers are 0.
- ENTER_A: `store_i` latches `operand_i` into A, then the FSM goes to ENTER_OP.
- ENTER_OP: on `store_i`, decode `operand_i[4:0]`: 10h ADD (op 0), 11h SUB (1), 12h MUL (2), 14h AND (3).
  - A valid code latches the op and goes to ENTER_B.
  - Any other value, including 0, sets `err_o` and stays in ENTER_OP.
- ENTER_B: `store_i` latches B and goes to WAIT_ALU.
- WAIT_ALU:
  - `alu_start_o` = 1 in the first cycle only.
  - `alu_a_o`, `alu_b_o` and `alu_op_o` stay stable for the whole state.
  - On `alu_done_i`, latch `result_o`, set `result_valid_o` and go to SHOW_RESULT.
  - If `ALU_TIMEOUT` cycles pass after the start cycle without done, set `err_o` and go to ENTER_A.
- SHOW_RESULT: `store_i` clears `result_valid_o`, A, B and op, then goes to ENTER_A (see Configuration).
- CLEAR (`key_valid_i` with code 15h):
  - From any state, go to ENTER_A next cycle.
  - Zero A, B, op, `result_o`, `result_valid_o`, `err_o` and the timeout counter.
  - Deassert `alu_start_o`.
  - An `alu_done_i` arriving later is ignored, because the state is no longer WAIT_ALU.
- `err_o` clears only on CLEAR or reset.
- `store_i` in WAIT_ALU is ignored.

## Timing
- All outputs are registered.
- `store_i` at edge N: the new state is visible on `calcstate_o` at N+1.
- Entering WAIT_ALU at N+1: `alu_start_o` = 1 during N+1 only.
- `alu_done_i` is honoured from cycle N+2 on. Done in the start cycle is ignored.
- Done at cycle M: `result_o`, `result_valid_o` and state SHOW_RESULT appear at M+1.
- Timeout counter: counts from 1 at N+2.
  - When it reaches `ALU_TIMEOUT` with no done, `err_o` = 1 and the state is ENTER_A on the next cycle.
  - Done in the same cycle as the timeout: done wins, no error.
- Priority within a cycle: reset > CLEAR > `alu_done_i` > timeout > `store_i`.

## Configuration
- `CALC_CHAIN_EN` defined: `store_i` in SHOW_RESULT copies `result_o` into A, clears B, op and `result_valid_o`, and goes to ENTER_OP. This allows chained operations.
- `CALC_CHAIN_EN` undefined: SHOW_RESULT behaves as described in Operation (return to ENTER_A with cleared values).

## Structure
- `calc_pkg` holds:
  - `calcstate_t` enum with the codes above;
  - key-code constants (KEY_ADD 10h, KEY_SUB 11h, KEY_MUL 12h, KEY_EXE 13h, KEY_AND 14h, KEY_CLR 15h);
  - `alu_op_t` enum.
- One sub-module, `calc_timeout_ctr`: loadable counter with clear/enable inputs, parameter `ALU_TIMEOUT`, and an `expired` output.

## Test plan
- A=0012h, op 10h, B=0034h; ALU returns done with 0046h three cycles after start → exactly one start pulse, then `result_o`=0046h, `result_valid_o`=1, `calcstate_o`=100.
- Store with operator 0 in ENTER_OP → `err_o`=1, state stays 010. CLEAR → `err_o`=0, state 000.
- ALU never responds, `ALU_TIMEOUT`=8 → `err_o`=1 and state 000 exactly 9 cycles after start.
- CLEAR in WAIT_ALU, then done with FFFFh two cycles later → `result_o`=0, `result_valid_o`=0, state 000.
- Done arriving in the same cycle as the timeout expires → result captured, `err_o`=0.
- With `CALC_CHAIN_EN`: result 0046h, then store → A=0046h, state 010. Without it → A=0, state 000.
